ipv4_hdr_gate: RTL and testbench

Frame-level gate between the RMII receive path and the IPv4 header checksum stage. It takes the MSB-first N-bit receive stream of one Ethernet frame, counts off the 14-byte MAC header and checks the Ethertype. For an IPv4 frame it forwards exactly IHL×4 header bytes, unmodified, as a contiguous valid burst for the ones-complement checksum. It also captures the header fields the packet classifier needs and flags malformed or truncated headers.

---
 rtl/eth_pkg.sv | 16 +
 rtl/ipv4_hdr_gate_byte_assembler.sv | 45 ++++
 rtl/ipv4_hdr_gate.sv | 152 +++++++++++++++
 tb/tb_ipv4_hdr_gate.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4 constants and the header-gate state type.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [6:0]  MAC_HDR_BYTES  = 7'd14;
  localparam logic [3:0]  IPV4_MIN_IHL   = 4'd5;
  localparam logic [3:0]  IPV4_VERSION   = 4'd4;

  typedef enum logic [1:0] {DRAIN, IDLE, MAC, HDR} gate_state_e;

  // Header byte 0 is acceptable when version is 4 and IHL covers the fixed header.
  function automatic logic ipv4_byte0_ok(input logic [7:0] b);
    return (b[7:4] == IPV4_VERSION) && (b[3:0] >= IPV4_MIN_IHL);
  endfunction

endpackage

// File: rtl/ipv4_hdr_gate_byte_assembler.sv
// Collects MSB-first N-bit beats into bytes; byte_valid marks the beat that completes a byte.
module byte_assembler #(
  parameter int N = 2,
  localparam int BPB = 8 / N,
  localparam int IDX_W = (BPB > 1) ? $clog2(BPB) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     beat,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic [IDX_W-1:0] beat_idx
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic             last_beat;

  assign last_beat = (idx_q == IDX_W'(BPB - 1));
  assign beat_idx  = idx_q;

  // byte_data includes the current beat, so the full byte is usable on the completing beat.
  always_comb begin
    byte_data  = (acc_q << N) | 8'(beat);
    byte_valid = en && last_beat;
    idx_d      = '0;
    acc_d      = acc_q;
    if (en) begin
      idx_d = last_beat ? '0 : idx_q + 1'b1;
      acc_d = byte_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ipv4_hdr_gate.sv
// Skips the MAC header, checks for IPv4 and forwards exactly IHL*4 header bytes
// as one contiguous burst while capturing protocol and addresses.
module ipv4_hdr_gate
  import eth_pkg::*;
#(
  parameter int N = 2,
  localparam int BPB = 8 / N,
  localparam int IDX_W = (BPB > 1) ? $clog2(BPB) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         hdr_done,
  output logic         hdr_err,
  output logic [3:0]   ihl,
  output logic [7:0]   protocol,
  output logic [31:0]  src_ip,
  output logic [31:0]  dst_ip
);

  gate_state_e state_q, state_d;
  logic [6:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  etype_hi_q, etype_hi_d;
  logic        axiov_q, axiov_d;
  logic [N-1:0] axiod_q, axiod_d;
  logic        hdr_done_q, hdr_done_d;
  logic        hdr_err_q, hdr_err_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [7:0]  protocol_q, protocol_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [31:0] dst_ip_q, dst_ip_d;

  logic             asm_en;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic [IDX_W-1:0] beat_idx_unused;
  logic [6:0]       hdr_last_byte;

  assign asm_en        = axiiv && (state_q != DRAIN);
  assign hdr_last_byte = {1'b0, ihl_q, 2'b00} - 7'd1;

  byte_assembler #(.N(N)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .en        (asm_en),
    .beat      (axiid),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .beat_idx  (beat_idx_unused)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    etype_hi_d = etype_hi_q;
    axiov_d    = 1'b0;
    axiod_d    = '0;
    hdr_done_d = 1'b0;
    hdr_err_d  = 1'b0;
    ihl_d      = ihl_q;
    protocol_d = protocol_q;
    src_ip_d   = src_ip_q;
    dst_ip_d   = dst_ip_q;

    // Byte counter indexes frame bytes in MAC and header bytes in HDR.
    if (state_q == DRAIN || state_q == IDLE) byte_cnt_d = '0;
    if (byte_valid) byte_cnt_d = byte_cnt_d + 7'd1;

    case (state_q)
      DRAIN: if (!axiiv) state_d = IDLE;
      IDLE:  if (axiiv) state_d = MAC;
      MAC: begin
        if (!axiiv) begin
          state_d = IDLE;
        end else if (byte_valid) begin
          if (byte_cnt_q == MAC_HDR_BYTES - 7'd2) etype_hi_d = byte_data;
          if (byte_cnt_q == MAC_HDR_BYTES - 7'd1) begin
            byte_cnt_d = '0;
            state_d    = ({etype_hi_q, byte_data} == ETHERTYPE_IPV4) ? HDR : DRAIN;
          end
        end
      end
      HDR: begin
        if (!axiiv) begin
          hdr_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          axiov_d = 1'b1;
          axiod_d = axiid;
          if (byte_valid) begin
            if (byte_cnt_q == 7'd0) begin
              if (!ipv4_byte0_ok(byte_data)) begin
                hdr_err_d = 1'b1;
                state_d   = DRAIN;
              end else begin
                ihl_d = byte_data[3:0];
              end
            end else if (byte_cnt_q == hdr_last_byte) begin
              hdr_done_d = 1'b1;
              state_d    = DRAIN;
            end
            if (byte_cnt_q == 7'd9) protocol_d = byte_data;
            if (byte_cnt_q >= 7'd12 && byte_cnt_q <= 7'd15) src_ip_d = {src_ip_q[23:0], byte_data};
            if (byte_cnt_q >= 7'd16 && byte_cnt_q <= 7'd19) dst_ip_d = {dst_ip_q[23:0], byte_data};
          end
        end
      end
      default: state_d = DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DRAIN;
      byte_cnt_q <= '0;
      etype_hi_q <= '0;
      axiov_q    <= 1'b0;
      axiod_q    <= '0;
      hdr_done_q <= 1'b0;
      hdr_err_q  <= 1'b0;
      ihl_q      <= '0;
      protocol_q <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      etype_hi_q <= etype_hi_d;
      axiov_q    <= axiov_d;
      axiod_q    <= axiod_d;
      hdr_done_q <= hdr_done_d;
      hdr_err_q  <= hdr_err_d;
      ihl_q      <= ihl_d;
      protocol_q <= protocol_d;
      src_ip_q   <= src_ip_d;
      dst_ip_q   <= dst_ip_d;
    end
  end

  assign axiov    = axiov_q;
  assign axiod    = axiod_q;
  assign hdr_done = hdr_done_q;
  assign hdr_err  = hdr_err_q;
  assign ihl      = ihl_q;
  assign protocol = protocol_q;
  assign src_ip   = src_ip_q;
  assign dst_ip   = dst_ip_q;

endmodule

// File: tb/tb_ipv4_hdr_gate.sv
// Frame-level bench for ipv4_hdr_gate: table vectors, corner sequences and random frames
// checked cycle-by-cycle against a per-frame expected output trace.
module tb_ipv4_hdr_gate;

  localparam int N    = 2;
  localparam int BPB  = 8 / N;
  localparam int MAXC = 40000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         axiiv = 1'b0;
  logic [N-1:0] axiid = '0;
  logic         axiov;
  logic [N-1:0] axiod;
  logic         hdr_done, hdr_err;
  logic [3:0]   ihl;
  logic [7:0]   protocol;
  logic [31:0]  src_ip, dst_ip;

  ipv4_hdr_gate #(.N(N)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov), .axiod(axiod), .hdr_done(hdr_done), .hdr_err(hdr_err),
    .ihl(ihl), .protocol(protocol), .src_ip(src_ip), .dst_ip(dst_ip)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bytes_t[$];
  typedef struct { logic [3:0] ihl; logic [7:0] proto; logic [31:0] src; logic [31:0] dst; } fld_t;
  typedef struct { logic [15:0] et; logic [7:0] b0; int len; int fwd; bit done; bit err; int lat; } vec_t;

  // Expected outputs indexed by absolute cycle; entry k reflects the input driven in cycle k-1.
  bit         exp_v    [MAXC];
  bit [N-1:0] exp_d    [MAXC];
  bit         exp_done [MAXC];
  bit         exp_err  [MAXC];
  fld_t       exp_fld  [int];

  int    cyc = 0, tests = 0, fails = 0;
  int    obs_beats, obs_done, obs_err, first_v, last_s;
  bit    frame_bad;
  string bad_msg;
  logic  rst_drv = 1'b0;

  function automatic logic [N-1:0] beat_of(input bytes_t fr, input int j);
    logic [7:0] b;
    int sh;
    b  = fr[j / BPB];
    sh = 8 - N * ((j % BPB) + 1);
    return N'(b >> sh);
  endfunction

  // Reference: what the gate must emit for one frame, derived from byte positions and lengths.
  function automatic void model_frame(input bytes_t fr, input int s);
    int L, H0, T, nf, k;
    logic [7:0] b0;
    fld_t f;
    L  = fr.size() * BPB;
    H0 = 14 * BPB;
    if (fr.size() < 14) return;
    if ({fr[12], fr[13]} != 16'h0800) return;
    if (fr.size() == 14) begin
      if (s + L + 1 < MAXC) exp_err[s + L + 1] = 1'b1;
      return;
    end
    b0 = fr[14];
    if (b0[7:4] != 4'd4 || b0[3:0] < 4'd5) begin
      for (int j = 0; j < BPB; j++) begin
        k = s + H0 + j + 1;
        if (k < MAXC) begin exp_v[k] = 1'b1; exp_d[k] = beat_of(fr, H0 + j); end
      end
      if (s + H0 + BPB < MAXC) exp_err[s + H0 + BPB] = 1'b1;
      return;
    end
    T  = int'(b0[3:0]) * 4 * BPB;
    nf = (L - H0 < T) ? L - H0 : T;
    for (int j = 0; j < nf; j++) begin
      k = s + H0 + j + 1;
      if (k < MAXC) begin exp_v[k] = 1'b1; exp_d[k] = beat_of(fr, H0 + j); end
    end
    if (L - H0 >= T) begin
      if (s + H0 + T < MAXC) exp_done[s + H0 + T] = 1'b1;
      f.ihl   = b0[3:0];
      f.proto = fr[23];
      f.src   = {fr[26], fr[27], fr[28], fr[29]};
      f.dst   = {fr[30], fr[31], fr[32], fr[33]};
      exp_fld[s + H0 + T] = f;
    end else if (s + L + 1 < MAXC) begin
      exp_err[s + L + 1] = 1'b1;
    end
  endfunction

  task automatic build_frame(input logic [15:0] et, input logic [7:0] b0, input int len,
                             input logic [7:0] proto, input logic [31:0] src, input logic [31:0] dst,
                             output bytes_t fr);
    logic [7:0]  hdr [60];
    logic [31:0] sum;
    int hl;
    fr = {};
    for (int i = 0; i < 12; i++) fr.push_back(8'($urandom));
    fr.push_back(et[15:8]);
    fr.push_back(et[7:0]);
    hl = (b0[3:0] < 4'd5) ? 20 : int'(b0[3:0]) * 4;
    for (int i = 0; i < 60; i++) hdr[i] = 8'($urandom);
    hdr[0] = b0;  hdr[9] = proto; hdr[10] = 8'h00; hdr[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      hdr[12 + i] = 8'(src >> (24 - 8 * i));
      hdr[16 + i] = 8'(dst >> (24 - 8 * i));
    end
    sum = 0;
    for (int i = 0; i < hl; i += 2) sum += {16'h0, hdr[i], hdr[i + 1]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    hdr[10] = ~sum[15:8];
    hdr[11] = ~sum[7:0];
    for (int i = 0; i < hl; i++) fr.push_back(hdr[i]);
    while (fr.size() < len) fr.push_back(8'($urandom));
    while (fr.size() > len) void'(fr.pop_back());
  endtask

  task automatic drive_cycle(input logic v, input logic [N-1:0] d);
    @(posedge clk);
    #1;
    if (cyc < MAXC) begin
      if (axiov !== exp_v[cyc] || hdr_done !== exp_done[cyc] || hdr_err !== exp_err[cyc] ||
          (exp_v[cyc] && axiod !== exp_d[cyc])) begin
        if (!frame_bad)
          bad_msg = $sformatf("cycle %0d got v=%b d=%h done=%b err=%b, required v=%b d=%h done=%b err=%b",
                              cyc, axiov, axiod, hdr_done, hdr_err,
                              exp_v[cyc], exp_d[cyc], exp_done[cyc], exp_err[cyc]);
        frame_bad = 1'b1;
      end
      if (exp_fld.exists(cyc)) begin
        tests++;
        if ({ihl, protocol, src_ip, dst_ip} !==
            {exp_fld[cyc].ihl, exp_fld[cyc].proto, exp_fld[cyc].src, exp_fld[cyc].dst}) begin
          fails++;
          $display("FAIL fields at cycle %0d: got ihl=%h proto=%h src=%h dst=%h, required ihl=%h proto=%h src=%h dst=%h",
                   cyc, ihl, protocol, src_ip, dst_ip,
                   exp_fld[cyc].ihl, exp_fld[cyc].proto, exp_fld[cyc].src, exp_fld[cyc].dst);
        end
      end
    end
    if (axiov === 1'b1) begin
      obs_beats++;
      if (first_v < 0) first_v = cyc;
    end
    if (hdr_done === 1'b1) obs_done++;
    if (hdr_err === 1'b1) obs_err++;
    rst   = rst_drv;
    axiiv = v;
    axiid = d;
    cyc++;
  endtask

  task automatic frame_begin();
    frame_bad = 1'b0;
    obs_beats = 0; obs_done = 0; obs_err = 0; first_v = -1;
  endtask

  task automatic frame_end(input string name);
    tests++;
    if (frame_bad) begin
      fails++;
      $display("FAIL trace %s: %s", name, bad_msg);
    end else begin
      $display("[TB] frame %s ok: beats=%0d done=%0d err=%0d", name, obs_beats, obs_done, obs_err);
    end
  endtask

  task automatic send_frame(input bytes_t fr, input int gap, input bit model_on, input string name);
    last_s = cyc;
    if (model_on) model_frame(fr, cyc);
    frame_begin();
    for (int j = 0; j < fr.size() * BPB; j++) drive_cycle(1'b1, beat_of(fr, j));
    for (int g = 0; g < gap; g++) drive_cycle(1'b0, '0);
    frame_end(name);
  endtask

  task automatic check_int(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t   vecs [8];
    bytes_t fr;
    logic [15:0] et;
    logic [7:0]  b0;
    int hl, len, s;

    vecs[0] = '{16'h0800, 8'h45, 44, 80,  1'b1, 1'b0, 57};
    vecs[1] = '{16'h0800, 8'h4F, 84, 240, 1'b1, 1'b0, 57};
    vecs[2] = '{16'h86DD, 8'h45, 44, 0,   1'b0, 1'b0, -1};
    vecs[3] = '{16'h0800, 8'h44, 44, 4,   1'b0, 1'b1, 57};
    vecs[4] = '{16'h0800, 8'h65, 44, 4,   1'b0, 1'b1, 57};
    vecs[5] = '{16'h0800, 8'h45, 25, 44,  1'b0, 1'b1, 57};
    vecs[6] = '{16'h0800, 8'h45, 8,  0,   1'b0, 1'b0, -1};
    vecs[7] = '{16'h0800, 8'h46, 44, 96,  1'b1, 1'b0, 57};

    // Reset state, then a frame whose first beat coincides with reset release.
    frame_begin();
    rst_drv = 1'b0;
    repeat (4) drive_cycle(1'b0, '0);
    tests++;
    if ({axiov, axiod, hdr_done, hdr_err, ihl, protocol, src_ip, dst_ip} !== '0) begin
      fails++;
      $display("FAIL reset_state: got v=%b d=%h done=%b err=%b ihl=%h proto=%h src=%h dst=%h, required all 0",
               axiov, axiod, hdr_done, hdr_err, ihl, protocol, src_ip, dst_ip);
    end
    frame_end("reset");
    rst_drv = 1'b1;
    build_frame(16'h0800, 8'h45, 44, 8'h06, 32'h0A000001, 32'h0A000002, fr);
    send_frame(fr, 1, 1'b0, "release_first_beat");
    build_frame(16'h0800, 8'h45, 44, 8'h06, 32'h0A000001, 32'h0A000002, fr);
    send_frame(fr, 3, 1'b1, "after_release");

    // Table vectors with hand-derived burst length, flags and latency.
    for (int v = 0; v < 8; v++) begin
      build_frame(vecs[v].et, vecs[v].b0, vecs[v].len, 8'h11, 32'hC0A80001, 32'hC0A80002, fr);
      send_frame(fr, 3, 1'b1, $sformatf("vec%0d", v));
      check_int($sformatf("vec%0d fwd_beats", v), obs_beats, vecs[v].fwd);
      check_int($sformatf("vec%0d done_pulses", v), obs_done, int'(vecs[v].done));
      check_int($sformatf("vec%0d err_pulses", v), obs_err, int'(vecs[v].err));
      check_int($sformatf("vec%0d latency", v), (first_v < 0) ? -1 : first_v - last_s, vecs[v].lat);
      if (vecs[v].done) begin
        tests++;
        if (protocol !== 8'h11 || src_ip !== 32'hC0A80001 || dst_ip !== 32'hC0A80002) begin
          fails++;
          $display("FAIL vec%0d held_fields: got proto=%h src=%h dst=%h, required 11 C0A80001 C0A80002",
                   v, protocol, src_ip, dst_ip);
        end
      end
    end

    // Back-to-back frames with single-cycle gaps.
    build_frame(16'h86DD, 8'h45, 44, 8'h11, 32'h01020304, 32'h05060708, fr);
    send_frame(fr, 1, 1'b1, "b2b_ipv6");
    build_frame(16'h0800, 8'h45, 40, 8'h11, 32'h01020304, 32'h05060708, fr);
    send_frame(fr, 1, 1'b1, "b2b_ipv4");
    build_frame(16'h0800, 8'h45, 25, 8'h01, 32'h11111111, 32'h22222222, fr);
    send_frame(fr, 1, 1'b1, "b2b_trunc");
    build_frame(16'h0800, 8'h47, 60, 8'h2F, 32'h33333333, 32'h44444444, fr);
    send_frame(fr, 2, 1'b1, "b2b_after_trunc");

    // Reset asserted in the middle of the header, released while that frame continues.
    build_frame(16'h0800, 8'h45, 40, 8'h11, 32'hC0A80001, 32'hC0A80002, fr);
    s = cyc;
    model_frame(fr, s);
    frame_begin();
    for (int j = 0; j < 70; j++) drive_cycle(1'b1, beat_of(fr, j));
    for (int c = cyc + 1; c < cyc + 400 && c < MAXC; c++) begin
      exp_v[c] = 1'b0; exp_done[c] = 1'b0; exp_err[c] = 1'b0;
      if (exp_fld.exists(c)) exp_fld.delete(c);
    end
    rst_drv = 1'b0;
    drive_cycle(1'b1, beat_of(fr, 70));
    drive_cycle(1'b1, beat_of(fr, 71));
    tests++;
    if ({axiov, axiod, hdr_done, hdr_err, ihl, protocol, src_ip, dst_ip} !== '0) begin
      fails++;
      $display("FAIL rst_mid_hdr: got v=%b d=%h done=%b err=%b ihl=%h proto=%h src=%h dst=%h, required all 0",
               axiov, axiod, hdr_done, hdr_err, ihl, protocol, src_ip, dst_ip);
    end
    drive_cycle(1'b1, beat_of(fr, 72));
    rst_drv = 1'b1;
    for (int j = 73; j < fr.size() * BPB; j++) drive_cycle(1'b1, beat_of(fr, j));
    drive_cycle(1'b0, '0);
    frame_end("rst_mid_hdr");
    build_frame(16'h0800, 8'h45, 44, 8'h11, 32'hC0A80001, 32'hC0A80002, fr);
    send_frame(fr, 2, 1'b1, "after_rst");

    // Randomized frames: mixed Ethertypes, header byte 0 values and truncation points.
    for (int i = 0; i < 40; i++) begin
      et  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'h0800;
      b0  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : {4'h4, 4'($urandom_range(5, 15))};
      hl  = (b0[3:0] < 4'd5) ? 20 : int'(b0[3:0]) * 4;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14 + hl))
                                        : 14 + hl + int'($urandom_range(0, 20));
      build_frame(et, b0, len, 8'($urandom), $urandom, $urandom, fr);
      send_frame(fr, int'($urandom_range(1, 3)), 1'b1, $sformatf("rand%0d", i));
    end

    frame_begin();
    repeat (4) drive_cycle(1'b0, '0);
    frame_end("flush");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
